// File: rtl/fetch_if.sv
// Bus between the fetch stage and its neighbours: instruction ROM, IF/ID
// register, hazard unit, redirect source and halt/go control.
interface fetch_if #(
  parameter int IMEM_AW = 10
);
  logic               stall;
  logic               redirect_en;
  logic [31:0]        redirect_pc;
  logic               halt;
  logic               go;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        ins_out;
  logic [31:0]        pc_out;
  logic [31:0]        pc_plus4_out;
  logic               status_out;
  logic               halted;
  logic [31:0]        fetch_count;

  modport master (
    input  stall, redirect_en, redirect_pc, halt, go, imem_data,
    output imem_addr, ins_out, pc_out, pc_plus4_out, status_out, halted,
           fetch_count
  );

  modport slave (
    output stall, redirect_en, redirect_pc, halt, go, imem_data,
    input  imem_addr, ins_out, pc_out, pc_plus4_out, status_out, halted,
           fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with next-PC selection, halt/run
// state machine and a counter of valid fetches accepted by IF/ID.
//
//   state  | meaning
//   RUN    | fetching; PC advances, redirects or holds on stall
//   HALTED | syscall halt seen; PC frozen until go
module fetch_stage #(
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_count;
  logic        status;

  assign pc_plus4 = pc + 32'd4;
  assign status   = (state == RUN) & ~bus.halt & ~bus.redirect_en & ~rst;

  assign bus.imem_addr    = pc[IMEM_AW+1:2];
  assign bus.ins_out      = bus.imem_data;
  assign bus.pc_out       = pc;
  assign bus.pc_plus4_out = pc_plus4;
  assign bus.status_out   = status;
  assign bus.halted       = (state == HALTED);
  assign bus.fetch_count  = fetch_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_count <= 32'd0;
    end else begin
      // halt wins over go, so a simultaneous pair lands in HALTED
      if (bus.halt)
        state <= HALTED;
      else if (state == HALTED && bus.go)
        state <= RUN;

      if (bus.halt || state == HALTED)
        pc <= pc;
      else if (bus.redirect_en)
        pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      else if (!bus.stall)
        pc <= pc_plus4;

      if (status && !bus.stall)
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
